// File: rtl/pbvi_pkg.sv
// Shared PBVI definitions: argmax FSM states, the "no action" code and
// the overflow-free accumulator width used by every PBVI dot-product stage.
package pbvi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_CMP,
      S_WRITE,
      S_DONE
   } state_e;

   // Result action code meaning "no enabled action"; real actions are 1-based.
   localparam int ACT_NONE = 0;

   // Width that holds a sum of ns products of two dw-bit unsigned values.
   function automatic int acc_width(input int dw, input int ns);
      return 2 * dw + $clog2(ns + 1);
   endfunction

endpackage

// File: rtl/pbvi_dot_mac.sv
// Registered unsigned multiply-accumulate. clr wins over en and loads zero;
// en adds the zero-extended DW x DW product into the accumulator.
module pbvi_dot_mac #(
   parameter int DW = 16,
   parameter int AW = 34
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] op_a,
   input  logic [DW-1:0] op_b,
   output logic [AW-1:0] acc
);

   logic [2*DW-1:0] prod;
   logic [AW-1:0]   acc_d;
   logic [AW-1:0]   acc_q;

   assign prod = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
   assign acc  = acc_q;

   // Next accumulator value: clear, accumulate, or hold.
   always_comb begin
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + AW'(prod);
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

endmodule

// File: rtl/pbvi_argmax_engine.sv
// Sequential PBVI best-action selector. For each belief b and action a the
// dot product belief(b) . alpha(a,b) is built on one MAC fed by two external
// one-cycle-latency memories; the best enabled action per belief is written
// out once per belief. Latency is data- and mask-independent.
module pbvi_argmax_engine
   import pbvi_pkg::*;
#(
   parameter int NUM_S = 2,
   parameter int NUM_A = 3,
   parameter int NUM_B = 16,
   parameter int DW    = 16,
   parameter int AW    = acc_width(DW, NUM_S)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_A-1:0]                     act_mask,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(NUM_B*NUM_S)-1:0]       b_addr,
   input  logic [DW-1:0]                        b_data,
   output logic [$clog2(NUM_A*NUM_B*NUM_S)-1:0] g_addr,
   input  logic [DW-1:0]                        g_data,
   output logic                                 res_we,
   output logic [$clog2(NUM_B)-1:0]             res_b,
   output logic [$clog2(NUM_A+1)-1:0]           res_a,
   output logic [AW-1:0]                        res_val
);

   localparam int BAW = $clog2(NUM_B*NUM_S);
   localparam int GAW = $clog2(NUM_A*NUM_B*NUM_S);
   localparam int RBW = $clog2(NUM_B);
   localparam int RAW = $clog2(NUM_A+1);
   localparam int SW  = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int AIW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
   localparam int BIW = (NUM_B > 1) ? $clog2(NUM_B) : 1;

   state_e           state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [AIW-1:0]   a_q, a_d;
   logic [BIW-1:0]   b_q, b_d;
   logic [NUM_A-1:0] mask_q, mask_d;
   logic [RAW-1:0]   best_a_q, best_a_d;
   logic [AW-1:0]    best_val_q, best_val_d;
   logic             res_we_q, res_we_d;
   logic [RBW-1:0]   res_b_q, res_b_d;
   logic [RAW-1:0]   res_a_q, res_a_d;
   logic [AW-1:0]    res_val_q, res_val_d;
   logic             mac_clr, mac_en;
   logic [AW-1:0]    acc;

   // The product of the data returned for s-1 is added while s is issued;
   // the last product lands in DRAIN, so acc is complete during CMP.
   pbvi_dot_mac #(.DW(DW), .AW(AW)) u_mac (
      .clk  (clk),
      .rst  (rst),
      .clr  (mac_clr),
      .en   (mac_en),
      .op_a (b_data),
      .op_b (g_data),
      .acc  (acc)
   );

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign res_we  = res_we_q;
   assign res_b   = res_b_q;
   assign res_a   = res_a_q;
   assign res_val = res_val_q;

   // Memory addresses are only driven while issuing; zero otherwise.
   always_comb begin
      b_addr = '0;
      g_addr = '0;
      if (state_q == S_ISSUE) begin
         b_addr = BAW'(32'(b_q) * 32'(NUM_S) + 32'(s_q));
         g_addr = GAW'((32'(a_q) * 32'(NUM_B) + 32'(b_q)) * 32'(NUM_S) + 32'(s_q));
      end
   end

   // Next-state, counters, running best and result staging.
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      a_d        = a_q;
      b_d        = b_q;
      mask_d     = mask_q;
      best_a_d   = best_a_q;
      best_val_d = best_val_q;
      res_we_d   = 1'b0;
      res_b_d    = res_b_q;
      res_a_d    = res_a_q;
      res_val_d  = res_val_q;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d     = act_mask;
               b_d        = '0;
               a_d        = '0;
               s_d        = '0;
               best_a_d   = '0;
               best_val_d = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Data on the bus at s=0 belongs to the previous pair: discard it.
            mac_clr = (s_q == '0);
            mac_en  = (s_q != '0);
            if (s_q == SW'(NUM_S-1)) begin
               s_d     = '0;
               state_d = S_DRAIN;
            end else begin
               s_d = s_q + SW'(1);
            end
         end
         S_DRAIN: begin
            mac_en  = 1'b1;
            state_d = S_CMP;
         end
         S_CMP: begin
            // Strict > keeps the lower action on ties.
            if (mask_q[a_q] && (best_a_q == RAW'(ACT_NONE) || acc > best_val_q)) begin
               best_a_d   = RAW'(a_q) + RAW'(1);
               best_val_d = acc;
            end
            if (a_q == AIW'(NUM_A-1)) begin
               // Stage the result so it is on the port during WRITE and holds after.
               res_we_d  = 1'b1;
               res_b_d   = RBW'(b_q);
               res_a_d   = best_a_d;
               res_val_d = best_val_d;
               state_d   = S_WRITE;
            end else begin
               a_d     = a_q + AIW'(1);
               state_d = S_ISSUE;
            end
         end
         S_WRITE: begin
            best_a_d   = '0;
            best_val_d = '0;
            a_d        = '0;
            if (b_q == BIW'(NUM_B-1)) begin
               state_d = S_DONE;
            end else begin
               b_d     = b_q + BIW'(1);
               state_d = S_ISSUE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any run in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         s_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         mask_q     <= '0;
         best_a_q   <= '0;
         best_val_q <= '0;
         res_we_q   <= 1'b0;
         res_b_q    <= '0;
         res_a_q    <= '0;
         res_val_q  <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mask_q     <= mask_d;
         best_a_q   <= best_a_d;
         best_val_q <= best_val_d;
         res_we_q   <= res_we_d;
         res_b_q    <= res_b_d;
         res_a_q    <= res_a_d;
         res_val_q  <= res_val_d;
      end
   end

endmodule

// File: doc/pbvi_argmax_engine.md
# pbvi_argmax_engine

Sequential, parametrised best-action selector for the PBVI backup. For every belief point it forms the dot product of the belief with each action's alpha vector, picks the maximising action, and streams one result per belief to the downstream value store. It replaces the fully unrolled single-cycle loop with a single-MAC datapath over external synchronous memories. It adds a start/done handshake, a per-run action mask and a fixed, data-independent latency.

## Interface
Parameters:
- NUM_S, 2, states per belief/alpha vector (≥1)
- NUM_A, 3, actions (≥1)
- NUM_B, 16, belief points (≥1)
- DW, 16, unsigned element width of belief and alpha entries
- AW, 2*DW+$clog2(NUM_S+1), accumulator/result width (overflow-free)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; accepted only in IDLE
- act_mask  in  NUM_A  bit j=1 enables action j; sampled on accepted start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse at end of run
- b_addr  out  $clog2(NUM_B*NUM_S)  belief read address = b*NUM_S+s
- b_data  in  DW  belief read data, valid one cycle after b_addr
- g_addr  out  $clog2(NUM_A*NUM_B*NUM_S)  alpha read address = (a*NUM_B+b)*NUM_S+s
- g_data  in  DW  alpha read data, valid one cycle after g_addr
- res_we  out  1  result write strobe
- res_b  out  $clog2(NUM_B)  belief index of result
- res_a  out  $clog2(NUM_A+1)  best action, 1-based; 0 = no enabled action
- res_val  out  AW  best dot product; 0 when res_a=0

## Operation
- FSM states: IDLE, ISSUE, DRAIN, CMP, WRITE, DONE.
- IDLE: start=1 latches act_mask, clears b and a to 0, and enters ISSUE.
- ISSUE: NUM_S cycles, s=0..NUM_S-1. Each cycle drives both addresses for (b,a,s). The product of the previous cycle's data is added to acc. acc clears at s=0.
- DRAIN: one cycle. Adds the final product. acc is then complete.
- CMP: one cycle. If act_mask[a] is set and (best_a==0 or acc>best_val), then best_val=acc and best_a=a+1. Ties keep the lower action. Masked actions are still fetched and accumulated, so latency is fixed. If a<NUM_A-1, increment a and go to ISSUE. Otherwise go to WRITE.
- WRITE: res_we=1 with res_b=b, res_a=best_a, res_val=best_val. Then clear best_a/best_val and set a=0. If b<NUM_B-1, increment b and go to ISSUE. Otherwise go to DONE.
- DONE: done=1, then IDLE.
- Arithmetic: unsigned DW×DW products, zero-extended to AW. The sum cannot wrap.
- start while not IDLE is ignored. act_mask changes mid-run have no effect.
- rst at any cycle forces IDLE and reset values. Rst mid-run produces no further writes and no done.

## Timing
- Reset values: busy=0, done=0, res_we=0, res_b=0, res_a=0, res_val=0, b_addr=0, g_addr=0.
- Per (b,a) pair: NUM_S+2 cycles. Per belief: NUM_A*(NUM_S+2)+1 cycles.
- With start accepted in cycle T, the first address appears in T+1.
- The write for belief b is in T+(b+1)*(NUM_A*(NUM_S+2)+1).
- done is in T+1+NUM_B*(NUM_A*(NUM_S+2)+1). Defaults give T+209, writes at T+13k.
- Memory read latency is exactly one cycle, with no stall input.
- res_* hold their value between strobes.
- A new start is accepted in the cycle after done.

## Structure
- pbvi_pkg: FSM state enum, ACT_NONE=0 constant, accumulator-width function shared with other PBVI steps.
- Sub-module pbvi_dot_mac: registered multiply-accumulate with clear and enable inputs, width AW, reused by the future backup-projection step.

## Test plan
Memory contents: b_s0[i]=i*0x1000, b_s1[i]=0xFFFF-b_s0[i], alpha (s0,s1) = a1:(1,3), a2:(2,2), a3:(3,1) for all b. All scenarios use default parameters.

- mask=3'b111 -> b=0: res_a=1, res_val=196605. b=7: res_a=1, res_val=139261. b=8: res_a=3, res_val=131071. 16 writes at T+13k, done at T+209.
- All alphas set to (2,2), mask=3'b111 -> every belief gives res_a=1 (tie keeps the lowest action), b=0 res_val=131070.
- mask=3'b110 -> b=0: res_a=2, res_val=131070. Timing is identical to the full-mask run.
- mask=3'b000 -> all 16 writes have res_a=0, res_val=0. done still at T+209.
- start pulsed at T+50, then rst at T+100 -> no start effect at T+50. After rst: no res_we and no done. busy=0 at T+101. A fresh start then yields correct results from b=0.
